// File: rtl/conv_add2nd_result_serializer_if.sv
// Bundle for the serializer: beat-wide input side from the adder array and
// word-wide valid/ready output side toward the feature-map writer.
interface conv_add2nd_result_serializer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NCH    = 16,
  parameter int unsigned CNT_W  = 5,
  parameter int unsigned POS_W  = 4
);
  localparam int unsigned CH_W = $clog2(NCH);

  logic                    in_valid;
  logic                    in_ready;
  logic [NCH*DATA_W-1:0]   in_data0;
  logic [NCH*DATA_W-1:0]   in_data1;
  logic [CNT_W-1:0]        cnt_in;
  logic [POS_W-1:0]        pos_in;

  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic [CH_W-1:0]         out_ch;
  logic                    out_col;
  logic [CNT_W-1:0]        out_cnt;
  logic [POS_W-1:0]        out_pos;
  logic                    out_last;

  // Serializer view
  modport slave (
    input  in_valid, in_data0, in_data1, cnt_in, pos_in, out_ready,
    output in_ready, out_valid, out_data, out_ch, out_col, out_cnt, out_pos, out_last
  );

  // Environment view: adder stage producing beats, writer consuming words
  modport master (
    output in_valid, in_data0, in_data1, cnt_in, pos_in, out_ready,
    input  in_ready, out_valid, out_data, out_ch, out_col, out_cnt, out_pos, out_last
  );
endinterface

// File: rtl/conv_add2nd_result_serializer.sv
// Two-slot ping-pong buffer that captures a 16-channel even/odd result beat and
// streams it as 2*NCH single words over valid/ready.
module conv_add2nd_result_serializer #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NCH     = 16,
  parameter int unsigned CNT_W   = 5,
  parameter int unsigned POS_W   = 4,
  parameter int unsigned CNT_MAX = 31,
  parameter int unsigned POS_MAX = 8
) (
  input  logic clk,
  input  logic rst_b,
  conv_add2nd_result_serializer_if.slave bus,
  output logic frame_done,
  output logic overrun_err
);
  localparam int unsigned IDX_W = $clog2(2*NCH);
  localparam int unsigned CH_W  = $clog2(NCH);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t                r_state, w_state_nxt;
  logic [NCH*DATA_W-1:0] r_d0 [2];
  logic [NCH*DATA_W-1:0] r_d1 [2];
  logic [CNT_W-1:0]      r_cnt [2];
  logic [POS_W-1:0]      r_pos [2];
  logic                  r_wr_ptr, r_rd_ptr;
  logic [1:0]            r_occ;
  logic [IDX_W-1:0]      r_word_idx;
  logic                  r_frame_done, r_overrun;

  logic                  w_in_ready, w_push, w_out_valid, w_pop, w_is_last, w_pop_last;
  logic [CH_W-1:0]       w_ch;
  logic                  w_col;
  logic [DATA_W-1:0]     w_word;

  assign w_in_ready  = (r_occ != 2'd2);
  assign w_push      = bus.in_valid & w_in_ready;
  assign w_out_valid = (r_state == S_STREAM);
  assign w_pop       = w_out_valid & bus.out_ready;
  assign w_is_last   = (r_word_idx == IDX_W'(2*NCH-1));
  assign w_pop_last  = w_pop & w_is_last;
  assign w_ch        = r_word_idx[IDX_W-1:1];
  assign w_col       = r_word_idx[0];

  // Beat storage carries no reset: validity is tracked solely by r_occ
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_d0[r_wr_ptr]  <= bus.in_data0;
      r_d1[r_wr_ptr]  <= bus.in_data1;
      r_cnt[r_wr_ptr] <= bus.cnt_in;
      r_pos[r_wr_ptr] <= bus.pos_in;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_occ        <= 2'd0;
      r_word_idx   <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (bus.in_valid && !w_in_ready) r_overrun <= 1'b1;
      if (w_pop) begin
        if (w_is_last) begin
          r_word_idx <= '0;
          r_rd_ptr   <= ~r_rd_ptr;
        end else begin
          r_word_idx <= r_word_idx + 1'b1;
        end
      end
      case ({w_push, w_pop_last})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
      r_frame_done <= w_pop_last
                      && (r_cnt[r_rd_ptr] == CNT_W'(CNT_MAX))
                      && (r_pos[r_rd_ptr] == POS_W'(POS_MAX));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_push) w_state_nxt = S_STREAM;
      S_STREAM: if (w_pop_last && !w_push && r_occ == 2'd1) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_word = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (w_ch == k[CH_W-1:0])
        w_word = w_col ? r_d1[r_rd_ptr][k*DATA_W +: DATA_W] : r_d0[r_rd_ptr][k*DATA_W +: DATA_W];
    end
  end

  // Outputs forced to zero when idle so stale slot contents never leak out
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_valid ? w_word : '0;
  assign bus.out_ch    = w_out_valid ? w_ch : '0;
  assign bus.out_col   = w_out_valid & w_col;
  assign bus.out_cnt   = w_out_valid ? r_cnt[r_rd_ptr] : '0;
  assign bus.out_pos   = w_out_valid ? r_pos[r_rd_ptr] : '0;
  assign bus.out_last  = w_out_valid & w_is_last;
  assign frame_done    = r_frame_done;
  assign overrun_err   = r_overrun;
endmodule

// File: tb/tb_conv_add2nd_result_serializer.sv
// Scoreboard bench: accepted beats expand into 32 expected words, checked
// against the output stream every cycle alongside an occupancy model.
module tb_conv_add2nd_result_serializer;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NCH    = 16;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  ch;
    logic        col;
    logic [4:0]  cnt;
    logic [3:0]  pos;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_b;
  logic frame_done, overrun_err;

  int n_checks = 0;
  int n_errors = 0;
  int fd_cnt   = 0;
  int m_occ    = 0;
  logic m_ovr  = 1'b0;
  logic exp_fd = 1'b0;
  exp_t q[$];

  always #5 clk = ~clk;

  conv_add2nd_result_serializer_if #(.DATA_W(32), .NCH(16), .CNT_W(5), .POS_W(4)) bus ();

  conv_add2nd_result_serializer #(
    .DATA_W(32), .NCH(16), .CNT_W(5), .POS_W(4), .CNT_MAX(31), .POS_MAX(8)
  ) dut (
    .clk(clk),
    .rst_b(rst_b),
    .bus(bus),
    .frame_done(frame_done),
    .overrun_err(overrun_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Per-cycle model, evaluated away from the active edge
  always @(negedge clk) begin
    if (!rst_b) begin
      q.delete();
      m_occ  = 0;
      m_ovr  = 1'b0;
      exp_fd = 1'b0;
      check_eq("rst_out_valid", bus.out_valid, 0);
      check_eq("rst_in_ready", bus.in_ready, 1);
      check_eq("rst_frame_done", frame_done, 0);
    end else begin
      logic pop, pop_last, push;
      check_eq("frame_done", frame_done, exp_fd);
      check_eq("overrun_err", overrun_err, m_ovr);
      check_eq("in_ready", bus.in_ready, (m_occ != 2));
      check_eq("out_valid", bus.out_valid, (m_occ != 0));
      if (frame_done) fd_cnt++;
      pop      = (m_occ != 0) && bus.out_ready;
      pop_last = 1'b0;
      exp_fd   = 1'b0;
      if (m_occ != 0) begin
        if (q.size() == 0) begin
          check_eq("sb_underflow", 1, 0);
        end else begin
          check_eq("out_data", bus.out_data, q[0].d);
          check_eq("out_ch",   bus.out_ch,   q[0].ch);
          check_eq("out_col",  bus.out_col,  q[0].col);
          check_eq("out_cnt",  bus.out_cnt,  q[0].cnt);
          check_eq("out_pos",  bus.out_pos,  q[0].pos);
          check_eq("out_last", bus.out_last, q[0].last);
          if (pop) begin
            pop_last = q[0].last;
            exp_fd   = q[0].last && (q[0].cnt == 5'd31) && (q[0].pos == 4'd8);
            void'(q.pop_front());
          end
        end
      end else begin
        check_eq("idle_out_data", bus.out_data, 0);
      end
      push = bus.in_valid && (m_occ != 2);
      if (bus.in_valid && m_occ == 2) m_ovr = 1'b1;
      if (push) begin
        for (int k = 0; k < NCH; k++) begin
          exp_t e;
          e.ch = 4'(k); e.cnt = bus.cnt_in; e.pos = bus.pos_in;
          e.d = bus.in_data0[k*DATA_W +: DATA_W]; e.col = 1'b0; e.last = 1'b0;
          q.push_back(e);
          e.d = bus.in_data1[k*DATA_W +: DATA_W]; e.col = 1'b1; e.last = (k == NCH-1);
          q.push_back(e);
        end
      end
      m_occ = m_occ + int'(push) - int'(pop_last);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [31:0] b0, input logic [31:0] b1,
                           input logic [4:0] cnt, input logic [3:0] pos);
    for (int k = 0; k < NCH; k++) begin
      bus.in_data0[k*DATA_W +: DATA_W] = b0 + 32'(k);
      bus.in_data1[k*DATA_W +: DATA_W] = b1 + 32'(k);
    end
    bus.cnt_in   = cnt;
    bus.pos_in   = pos;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input bit rnd, output int cyc);
    cyc = 0;
    while (bus.out_valid && cyc < 2000) begin
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    bus.out_ready = 1'b1;
    if (cyc >= 2000) check_eq("drain_timeout", 1, 0);
  endtask

  task automatic wait_word(input logic [3:0] ch, input logic col, input bit want_last);
    int n = 0;
    while (n < 200 && !(bus.out_valid && (want_last ? bus.out_last : (bus.out_ch == ch && bus.out_col == col)))) begin
      tick();
      n++;
    end
    if (n >= 200) check_eq("wait_timeout", 1, 0);
  endtask

  initial begin
    int cyc;
    rst_b         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data0  = '0;
    bus.in_data1  = '0;
    bus.cnt_in    = '0;
    bus.pos_in    = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    check_eq("reset_in_ready", bus.in_ready, 1);
    check_eq("reset_out_data", bus.out_data, 0);
    check_eq("reset_overrun", overrun_err, 0);
    rst_b = 1'b1;
    tick();

    // 1: single beat at full rate
    bus.out_ready = 1'b1;
    push_beat(32'd100, 32'd200, 5'd3, 4'd2);
    drain(1'b0, cyc);
    check_eq("t1_cycles", cyc, 32);
    check_eq("t1_sb_empty", q.size(), 0);

    // 2: fill both slots under backpressure, third beat is dropped
    bus.out_ready = 1'b0;
    push_beat(32'h1000_0000, 32'h2000_0000, 5'd1, 4'd1);
    push_beat(32'hFFFF_FFF0, 32'h8000_0000, 5'd2, 4'd3);
    check_eq("t2_full", bus.in_ready, 0);
    push_beat(32'hDEAD_0000, 32'hBEEF_0000, 5'd7, 4'd7);
    tick();
    check_eq("t2_overrun", overrun_err, 1);
    bus.out_ready = 1'b1;
    drain(1'b0, cyc);
    check_eq("t2_cycles", cyc, 64);
    check_eq("t2_sb_empty", q.size(), 0);

    // 3: end-of-frame beat with random backpressure
    push_beat($urandom, $urandom, 5'd31, 4'd8);
    drain(1'b1, cyc);
    tick();
    check_eq("t3_fd_pulses", fd_cnt, 1);

    // 4: push coincident with last-word pop keeps streaming without a bubble
    bus.out_ready = 1'b1;
    push_beat(32'd5000, 32'd6000, 5'd4, 4'd5);
    wait_word(4'd0, 1'b0, 1'b1);
    push_beat(32'd7000, 32'd8000, 5'd6, 4'd0);
    check_eq("t4_no_bubble", bus.out_valid, 1);
    check_eq("t4_word0_ch", {bus.out_ch, bus.out_col}, 0);
    check_eq("t4_in_ready", bus.in_ready, 1);
    drain(1'b0, cyc);
    check_eq("t4_cycles", cyc, 32);

    // 5: reset in the middle of a beat
    push_beat(32'd300, 32'd400, 5'd9, 4'd1);
    wait_word(4'd5, 1'b0, 1'b0);
    rst_b = 1'b0;
    #1;
    check_eq("t5_out_valid", bus.out_valid, 0);
    check_eq("t5_out_data", bus.out_data, 0);
    check_eq("t5_out_last", bus.out_last, 0);
    check_eq("t5_in_ready", bus.in_ready, 1);
    check_eq("t5_overrun", overrun_err, 0);
    tick();
    rst_b = 1'b1;
    tick();
    push_beat(32'd900, 32'd950, 5'd10, 4'd2);
    check_eq("t5_restart_idx", {bus.out_ch, bus.out_col}, 0);
    drain(1'b0, cyc);
    check_eq("t5_cycles", cyc, 32);
    tick();
    check_eq("final_sb_empty", q.size(), 0);
    check_eq("final_fd_pulses", fd_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
